sample_replay_ctrl: RTL and testbench
=====================================

// Module: sample_replay_ctrl
// PURPOSE
//  Sequences the read side of sample_fifo for training: streams a batch of samples to a tree engine,
//  rewinds (i_read_rst) to replay the same batch for N passes, then marks the next batch and continues.
//  Owns pop/mark/rewind/flush of the FIFO; sits between sample_fifo and the tree-build datapath.
// PARAMETERS
//  FIFO_WIDTH      16  sample word width
//  CNT_W           12  width of batch-length / pass / batch counters
//  READ_LAT        3   FIFO pop -> i_fifo_vld latency (cycles)
//  BUF_DEPTH       4   output buffer entries; must be >= READ_LAT+1
// PORTS
//  clk               in   1           clock
//  rst_n             in   1           reset rst_n, synchronous, active-low; clock clk
//  i_start           in   1           start job (sampled in IDLE only)
//  i_batch_len       in   CNT_W       samples per batch (>=1), latched on start
//  i_num_passes      in   CNT_W       replays per batch (>=1), latched on start
//  i_num_batches     in   CNT_W       batches per job (>=1), latched on start
//  i_flush_on_done   in   1           flush FIFO at job end
//  o_fifo_pop        out  1           -> sample_fifo i_pop
//  o_fifo_mark       out  1           -> i_mark_read_rst
//  o_fifo_rewind     out  1           -> i_read_rst
//  o_fifo_flush      out  1           -> i_flush
//  i_fifo_front      in   FIFO_WIDTH  <- o_front
//  i_fifo_vld        in   1           <- o_vld
//  i_fifo_empty      in   1           <- o_empty
//  o_smp_data        out  FIFO_WIDTH  sample to engine
//  o_smp_vld         out  1           valid; data held stable until rdy
//  i_smp_rdy         in   1           engine ready
//  o_smp_last        out  1           last sample of current pass (with vld)
//  o_pass_idx        out  CNT_W       current pass index
//  o_batch_idx       out  CNT_W       current batch index
//  o_busy            out  1           job in progress
//  o_done            out  1           1-cycle pulse at job completion
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, buffer empty, counters 0. Reset mid-job aborts; no flush issued.
//  - States: IDLE -> MARK -> STREAM -> DRAIN -> {REWIND->STREAM | MARK | FINISH} ; FINISH -> IDLE.
//  - IDLE: o_busy=0. i_start latches params, o_busy=1 next cycle, -> MARK.
//  - MARK: 2 cycles no pops (FIFO mark captures rptr delayed 1 cycle), then o_fifo_mark 1 cycle, -> STREAM.
//  - STREAM: pop when !i_fifo_empty && issued<batch_len && (inflight+buf_count)<BUF_DEPTH.
//    inflight = pops in READ_LAT-deep shift reg; credit guarantees no buffer overflow, no vld dropped.
//  - Dropped pop: FIFO may ignore pop (almost_empty). If shift-reg tail=1 and i_fifo_vld=0 in same
//    cycle, issued count decrements (pop re-issued). i_fifo_vld with tail=0 is an error (assert).
//  - All batch_len pops returned -> DRAIN: wait buffer empty (all samples accepted downstream).
//  - DRAIN exit: pass<num_passes-1 -> REWIND (pass++); else batch<num_batches-1 -> MARK (batch++, pass=0);
//    else FINISH.
//  - REWIND: o_fifo_rewind 1 cycle, then 2 idle cycles before first pop, -> STREAM.
//  - FINISH: o_fifo_flush 1 cycle iff i_flush_on_done; o_done pulse; -> IDLE same cycle as pulse.
//  - Output: vld/data from buffer head; pop buffer on vld&&rdy; o_smp_last when accepted count==batch_len-1.
//  - Push and pop of buffer in same cycle allowed; count unchanged. FIFO empty stalls, never errors.
//  - o_fifo_mark/rewind/flush never coincide with o_fifo_pop; all 1-cycle pulses.
// STRUCTURE
//  - Package sample_replay_pkg: state_e enum (IDLE,MARK,STREAM,DRAIN,REWIND,FINISH), MARK_SETTLE=2,
//    REWIND_SETTLE=2.
//  - Sub-module smp_out_buf: BUF_DEPTH x FIFO_WIDTH register FIFO with count, first-word fall-through.
//  - Top: FSM, pop credit/shift reg, issued/accepted/pass/batch counters.
// TESTING
//  1 batch=4,passes=1,batches=1, FIFO holds 4, rdy=1 -> 4 beats, last on 4th, done pulse, 1 mark, 0 rewind.
//  2 batch=3,passes=3 FIFO {A,B,C} -> A,B,C x3 in order, o_pass_idx 0,1,2, two rewind pulses.
//  3 batch=2,batches=2 FIFO {A,B,C,D}, passes=2 -> A,B,A,B,C,D,C,D; mark pulsed twice.
//  4 rdy toggled random 50%, batch=8 -> no sample lost/duplicated, inflight+buf never > BUF_DEPTH.
//  5 FIFO fed 1 word per 10 cycles during STREAM (forces empty/dropped pops) -> exact sequence, done.
//  6 rst_n low mid-STREAM -> next cycle all outputs 0, IDLE; i_flush_on_done=1 job -> one flush pulse at end.

Source files
------------

// File: rtl/sample_replay_pkg.sv
// Shared types and constants for the sample replay controller.
package sample_replay_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MARK   = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    REWIND = 3'd4,
    FINISH = 3'd5
  } state_e;

  // Quiet cycles after entering MARK before the mark pulse; the FIFO samples
  // its read pointer one cycle late, so the pointer must be stable first.
  localparam int MARK_SETTLE   = 2;
  // Quiet cycles after the rewind pulse before the first pop of a replay.
  localparam int REWIND_SETTLE = 2;
  // Width of the settle counter shared by MARK and REWIND.
  localparam int SETTLE_W      = 2;

endpackage

// File: rtl/smp_out_buf.sv
// Small register FIFO with first-word fall-through that holds samples
// returned by sample_fifo until the tree engine accepts them.
module smp_out_buf #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_vld,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head_vld  = (cnt_q != '0);
  assign head_data = head_vld ? mem[rd_ptr] : '0;
  assign count     = cnt_q;
  assign do_pop    = pop && head_vld;

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep the count.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)   wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Sample storage.
  // NOTE: storage is not reset; head_data is gated by head_vld so stale words never reach the output.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // The pop credit in the controller must make a push into a full buffer impossible.
  always @(posedge clk) begin
    if (rst_n) assert (!(push && (cnt_q == CNT_W'(DEPTH)) && !do_pop));
  end

endmodule

// File: rtl/sample_replay_ctrl.sv
// Read-side sequencer for sample_fifo: marks a batch, streams it to the tree
// engine, rewinds to replay it for each pass, then moves to the next batch.
module sample_replay_ctrl
  import sample_replay_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_W      = 12,
  parameter int READ_LAT   = 3,
  parameter int BUF_DEPTH  = 4    // must be at least READ_LAT+1 for full throughput
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic [CNT_W-1:0]      i_batch_len,
  input  logic [CNT_W-1:0]      i_num_passes,
  input  logic [CNT_W-1:0]      i_num_batches,
  input  logic                  i_flush_on_done,
  output logic                  o_fifo_pop,
  output logic                  o_fifo_mark,
  output logic                  o_fifo_rewind,
  output logic                  o_fifo_flush,
  input  logic [FIFO_WIDTH-1:0] i_fifo_front,
  input  logic                  i_fifo_vld,
  input  logic                  i_fifo_empty,
  output logic [FIFO_WIDTH-1:0] o_smp_data,
  output logic                  o_smp_vld,
  input  logic                  i_smp_rdy,
  output logic                  o_smp_last,
  output logic [CNT_W-1:0]      o_pass_idx,
  output logic [CNT_W-1:0]      o_batch_idx,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int BCNT_W = $clog2(BUF_DEPTH + 1);
  localparam int OCC_W  = $clog2(BUF_DEPTH + READ_LAT + 1);

  state_e               state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q;
  logic [CNT_W-1:0]     len_q, passes_q, batches_q;
  logic                 flush_q;
  logic [CNT_W-1:0]     issued_q, accepted_q, pass_q, batch_q;
  logic [READ_LAT-1:0]  sr_q;

  logic                 sr_tail, dropped;
  logic                 buf_push, buf_pop, buf_vld;
  logic [FIFO_WIDTH-1:0] buf_data;
  logic [BCNT_W-1:0]    buf_count;
  logic [OCC_W-1:0]     occ;
  logic                 stream_done, drain_done, more_passes, more_batches;

  // A pop reaching the end of the latency pipe either returns a word or was
  // silently ignored by the FIFO; ignored pops are handed back to the issue count.
  assign sr_tail  = sr_q[READ_LAT-1];
  assign buf_push = sr_tail && i_fifo_vld;
  assign dropped  = sr_tail && !i_fifo_vld;
  assign buf_pop  = buf_vld && i_smp_rdy;

  // Words that may still land in the buffer plus words already in it.
  assign occ = OCC_W'($countones(sr_q)) + OCC_W'(buf_count);

  assign stream_done  = (issued_q == len_q) && (sr_q == '0);
  assign drain_done   = (buf_count == '0);
  assign more_passes  = pass_q  < (passes_q  - CNT_W'(1));
  assign more_batches = batch_q < (batches_q - CNT_W'(1));

  smp_out_buf #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data (i_fifo_front),
    .pop       (buf_pop),
    .head_data (buf_data),
    .head_vld  (buf_vld),
    .count     (buf_count)
  );

  assign o_smp_vld   = buf_vld;
  assign o_smp_data  = buf_data;
  assign o_smp_last  = buf_vld && (accepted_q == (len_q - CNT_W'(1)));
  assign o_pass_idx  = pass_q;
  assign o_batch_idx = batch_q;
  assign o_busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (i_start) state_d = MARK;
      MARK:    if (settle_q == SETTLE_W'(MARK_SETTLE)) state_d = STREAM;
      STREAM:  if (stream_done) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = more_passes  ? REWIND :
                                         more_batches ? MARK   : FINISH;
      REWIND:  if (settle_q == SETTLE_W'(REWIND_SETTLE)) state_d = STREAM;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO control pulses and job-done pulse decoded from the current state.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    o_fifo_pop    = 1'b0;
    o_fifo_mark   = 1'b0;
    o_fifo_rewind = 1'b0;
    o_fifo_flush  = 1'b0;
    o_done        = 1'b0;
    case (state_q)
      MARK:    o_fifo_mark   = (settle_q == SETTLE_W'(MARK_SETTLE));
      STREAM:  o_fifo_pop    = !i_fifo_empty && (issued_q < len_q) &&
                               (occ < OCC_W'(BUF_DEPTH));
      REWIND:  o_fifo_rewind = (settle_q == '0);
      FINISH: begin
        o_fifo_flush = flush_q;
        o_done       = 1'b1;
      end
      default: ;
    endcase
  end

  // Settle counter: restarts on every state change, counts inside MARK/REWIND.
  always_ff @(posedge clk) begin
    if (!rst_n)                                   settle_q <= '0;
    else if (state_d != state_q)                  settle_q <= '0;
    else if (state_q == MARK || state_q == REWIND) settle_q <= settle_q + SETTLE_W'(1);
  end

  // Job parameters captured when a job starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      passes_q  <= '0;
      batches_q <= '0;
      flush_q   <= 1'b0;
    end else if (state_q == IDLE && i_start) begin
      len_q     <= i_batch_len;
      passes_q  <= i_num_passes;
      batches_q <= i_num_batches;
      flush_q   <= i_flush_on_done;
    end
  end

  // Pass/batch position and per-pass issue/accept counts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pass_q     <= '0;
      batch_q    <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
    end else begin
      if (state_q == IDLE && i_start) begin
        pass_q  <= '0;
        batch_q <= '0;
      end else if (state_q == DRAIN && drain_done) begin
        if (more_passes) begin
          pass_q <= pass_q + CNT_W'(1);
        end else if (more_batches) begin
          batch_q <= batch_q + CNT_W'(1);
          pass_q  <= '0;
        end
      end

      if (state_q == STREAM) issued_q <= issued_q + CNT_W'(o_fifo_pop) - CNT_W'(dropped);
      else                   issued_q <= '0;

      if (state_q == STREAM || state_q == DRAIN) begin
        if (buf_pop) accepted_q <= accepted_q + CNT_W'(1);
      end else begin
        accepted_q <= '0;
      end
    end
  end

  // Latency pipe tracking which cycles should bring a word back from the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= o_fifo_pop;
      for (int i = 1; i < READ_LAT; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  // A returned word with no matching pop means the FIFO and controller disagree.
  always @(posedge clk) begin
    if (rst_n) assert (!(i_fifo_vld && !sr_tail));
  end

endmodule

// File: tb/tb_sample_replay_ctrl.sv
// Randomized bench for sample_replay_ctrl: a sample_fifo environment model
// (mark/rewind/flush, read latency, ignored pops) feeds the DUT, and every
// accepted beat is checked against the batch/pass/sample order of the job.
module tb_sample_replay_ctrl;

  localparam int FW  = 16;
  localparam int CW  = 12;
  localparam int LAT = 3;
  localparam int BD  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_start;
  logic [CW-1:0] i_batch_len, i_num_passes, i_num_batches;
  logic          i_flush_on_done;
  logic          o_fifo_pop, o_fifo_mark, o_fifo_rewind, o_fifo_flush;
  logic [FW-1:0] i_fifo_front;
  logic          i_fifo_vld, i_fifo_empty;
  logic [FW-1:0] o_smp_data;
  logic          o_smp_vld, i_smp_rdy, o_smp_last;
  logic [CW-1:0] o_pass_idx, o_batch_idx;
  logic          o_busy, o_done;

  always #5 clk = ~clk;

  sample_replay_ctrl #(
    .FIFO_WIDTH (FW),
    .CNT_W      (CW),
    .READ_LAT   (LAT),
    .BUF_DEPTH  (BD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_batch_len     (i_batch_len),
    .i_num_passes    (i_num_passes),
    .i_num_batches   (i_num_batches),
    .i_flush_on_done (i_flush_on_done),
    .o_fifo_pop      (o_fifo_pop),
    .o_fifo_mark     (o_fifo_mark),
    .o_fifo_rewind   (o_fifo_rewind),
    .o_fifo_flush    (o_fifo_flush),
    .i_fifo_front    (i_fifo_front),
    .i_fifo_vld      (i_fifo_vld),
    .i_fifo_empty    (i_fifo_empty),
    .o_smp_data      (o_smp_data),
    .o_smp_vld       (o_smp_vld),
    .i_smp_rdy       (i_smp_rdy),
    .o_smp_last      (o_smp_last),
    .o_pass_idx      (o_pass_idx),
    .o_batch_idx     (o_batch_idx),
    .o_busy          (o_busy),
    .o_done          (o_done)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sample_fifo environment: storage with write/read/mark pointers and a read-latency pipe.
  logic [FW-1:0] mem [256];
  int            wptr, rptr, mark_ptr;
  logic          pipe_r [LAT];
  logic          pipe_v [LAT];
  logic [FW-1:0] pipe_d [LAT];
  int            ret_cnt, acc_cnt;

  task automatic env_reset();
    wptr = 0; rptr = 0; mark_ptr = 0; ret_cnt = 0; acc_cnt = 0;
    for (int j = 0; j < LAT; j++) begin
      pipe_r[j] = 1'b0; pipe_v[j] = 1'b0; pipe_d[j] = '0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {24'h0, o_fifo_pop, o_fifo_mark, o_fifo_rewind, o_fifo_flush,
                           o_smp_vld, o_smp_last, o_busy, o_done}, 32'h0);
    check({tag, "_data"}, {16'h0, o_smp_data}, 32'h0);
    check({tag, "_idx"},  {8'h0, o_pass_idx, o_batch_idx}, 32'h0);
  endtask

  // Runs one job; stop_at>0 abandons it after that many cycles without end-of-job checks.
  task automatic run_job(input int len, input int passes, input int batches, input bit flush,
                         input int rdy_pct, input bit trickle, input int drop_pct,
                         input int stop_at, input string name);
    logic [FW-1:0] jw [$];
    logic [FW-1:0] prev_data;
    bit   prev_stall;
    int   n, total, k, fed, dones, marks, rewinds, flushes, max_occ, cyc, tail;
    int   b, p, i, occ;
    n = len * batches;
    total = len * passes * batches;
    k = 0; fed = 0; dones = 0; marks = 0; rewinds = 0; flushes = 0;
    max_occ = 0; cyc = 0; tail = -1; prev_stall = 1'b0; prev_data = '0;
    for (int j = 0; j < n; j++) jw.push_back(FW'($urandom));
    if (!trickle) begin
      for (int j = 0; j < n; j++) begin
        mem[wptr % 256] = jw[j];
        wptr++;
      end
      fed = n;
    end

    while (cyc < 20000) begin
      @(negedge clk);
      if (trickle && fed < n && (cyc % 10) == 0) begin
        mem[wptr % 256] = jw[fed];
        wptr++;
        fed++;
      end
      i_start         = (cyc == 0);
      i_batch_len     = CW'(len);
      i_num_passes    = CW'(passes);
      i_num_batches   = CW'(batches);
      i_flush_on_done = flush;
      i_smp_rdy       = ($urandom_range(99) < rdy_pct);
      i_fifo_vld      = pipe_v[LAT-1];
      i_fifo_front    = pipe_v[LAT-1] ? pipe_d[LAT-1] : '0;
      i_fifo_empty    = (rptr == wptr);
      #1;

      if (cyc == 0) check({name, "_busy_idle"}, o_busy, 1'b0);
      if (cyc == 1) check({name, "_busy_after_start"}, o_busy, 1'b1);

      occ = ret_cnt - acc_cnt + int'(o_fifo_pop);
      for (int j = 0; j < LAT; j++) occ += int'(pipe_r[j]);
      if (occ > max_occ) max_occ = occ;

      if (prev_stall) begin
        check({name, "_hold_vld"},  o_smp_vld, 1'b1);
        check({name, "_hold_data"}, o_smp_data, prev_data);
      end
      prev_stall = o_smp_vld && !i_smp_rdy;
      prev_data  = o_smp_data;

      if (o_smp_vld && i_smp_rdy) begin
        if (k < total) begin
          b = k / (len * passes);
          p = (k % (len * passes)) / len;
          i = k % len;
          check({name, "_data"},  o_smp_data, jw[b * len + i]);
          check({name, "_last"},  o_smp_last, (i == len - 1));
          check({name, "_pass"},  o_pass_idx, p);
          check({name, "_batch"}, o_batch_idx, b);
        end else begin
          check({name, "_extra_beat"}, k, total - 1);
        end
        k++;
        acc_cnt++;
      end

      if (o_fifo_mark || o_fifo_rewind || o_fifo_flush)
        check({name, "_pulse_vs_pop"}, o_fifo_pop, 1'b0);
      if (o_fifo_pop && i_fifo_empty)
        check({name, "_pop_when_empty"}, o_fifo_pop, 1'b0);

      marks   += int'(o_fifo_mark);
      rewinds += int'(o_fifo_rewind);
      flushes += int'(o_fifo_flush);
      dones   += int'(o_done);
      if (o_done && tail < 0) tail = LAT + 1;

      // Environment reacts to what the DUT drives into this clock edge.
      if (i_fifo_vld) ret_cnt++;
      for (int j = LAT - 1; j > 0; j--) begin
        pipe_r[j] = pipe_r[j-1]; pipe_v[j] = pipe_v[j-1]; pipe_d[j] = pipe_d[j-1];
      end
      pipe_r[0] = o_fifo_pop;
      pipe_v[0] = 1'b0;
      pipe_d[0] = '0;
      if (o_fifo_pop && rptr != wptr && $urandom_range(99) >= drop_pct) begin
        pipe_v[0] = 1'b1;
        pipe_d[0] = mem[rptr % 256];
        rptr++;
      end
      if (o_fifo_mark)   mark_ptr = rptr;
      if (o_fifo_rewind) rptr = mark_ptr;
      if (o_fifo_flush) begin
        rptr = 0; wptr = 0; mark_ptr = 0;
      end

      cyc++;
      if (stop_at > 0 && cyc >= stop_at) return;
      if (tail > 0) begin
        tail--;
        if (tail == 0) break;
      end
    end

    check({name, "_beats"},   k, total);
    check({name, "_dones"},   dones, 1);
    check({name, "_marks"},   marks, batches);
    check({name, "_rewinds"}, rewinds, batches * (passes - 1));
    check({name, "_flushes"}, flushes, int'(flush));
    check({name, "_busy_end"}, o_busy, 1'b0);
    check({name, "_max_occ_ok"}, (max_occ <= BD), 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0;
    i_batch_len = '0; i_num_passes = '0; i_num_batches = '0; i_flush_on_done = 1'b0;
    i_smp_rdy = 1'b0; i_fifo_vld = 1'b0; i_fifo_front = '0; i_fifo_empty = 1'b1;
    env_reset();
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    run_job(4, 1, 1, 1'b0, 100, 1'b0,  0, 0, "t1_single");
    run_job(3, 3, 1, 1'b0, 100, 1'b0,  0, 0, "t2_passes");
    run_job(2, 2, 2, 1'b0, 100, 1'b0,  0, 0, "t3_batches");
    run_job(8, 2, 2, 1'b0,  50, 1'b0,  0, 0, "t4_rdy_rand");
    run_job(5, 2, 2, 1'b0,  80, 1'b1, 30, 0, "t5_trickle");

    run_job(12, 1, 1, 1'b0, 100, 1'b0, 0, 10, "t6_abort");
    check("t6_busy_before_abort", o_busy, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; i_start = 1'b0; i_fifo_vld = 1'b0; i_fifo_front = '0;
    @(posedge clk);
    #1;
    check_zero("abort_reset");
    env_reset();
    i_fifo_empty = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    run_job(3, 2, 2, 1'b1, 70, 1'b0, 20, 0, "t6_flush");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
